// File: rtl/imem_loader_if.sv
// Loader-side bundle: byte-stream handshake in, instruction-memory write port and status out.
// master = stream source / boot controller, slave = imem_loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte stream -> 32-bit imem writes with XOR check; write one cycle after the 4th byte of a word.
// byte_ready drops during each WRITE cycle (4 bytes / 5 cycles); core held in reset until a clean load.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input logic         clk,
  input logic         rst_n,
  imem_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  logic [2:0]  state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [7:0]  acc;
  logic [31:0] word;

  logic        accept;
  logic [15:0] len_n;

  assign accept = bus.byte_valid & bus.byte_ready;
  // Full word count as it will be once the LEN_HI byte lands.
  assign len_n  = {bus.byte_data, len[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      len   <= '0;
      idx   <= '0;
      bcnt  <= '0;
      acc   <= '0;
      word  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) state <= S_LEN_LO;
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.byte_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.byte_data;
            idx       <= '0;
            bcnt      <= '0;
            acc       <= '0;
            if (len_n == 16'd0 || {1'b0, len_n} > MAX_N) state <= S_ERR;
            else                                         state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            word[{bcnt, 3'b000} +: 8] <= bus.byte_data;
            acc  <= acc ^ bus.byte_data;
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (idx == len - 16'd1) begin
            state <= S_CSUM;
          end else begin
            idx   <= idx + 16'd1;
            state <= S_DATA;
          end
        end
        S_CSUM: begin
          if (accept) state <= (bus.byte_data == acc) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Every output is a decode of registered state/data, never of the inputs.
  assign bus.byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                          (state == S_DATA)   || (state == S_CSUM);
  assign bus.busy       = bus.byte_ready || (state == S_WRITE);
  assign bus.mem_we     = (state == S_WRITE);
  assign bus.mem_addr   = idx[ADDR_W-1:0];
  assign bus.mem_wdata  = word;
  assign bus.cpu_rst_n  = (state == S_DONE);
  assign bus.done       = (state == S_DONE);
  assign bus.err        = (state == S_ERR);

endmodule
